// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: a single registered multiplier is stepped across all
// taps, one MAC pass of NTAPS+1 cycles per accepted sample, with valid/ready
// handshakes on both the sample input and the result output.
module fir_mac_sequencer #(
  parameter int NTAPS = 8,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int ACCW  = DW + CW + $clog2(NTAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coeff_wr_en,
  input  logic [$clog2(NTAPS)-1:0] coeff_wr_addr,
  input  logic [CW-1:0]            coeff_wr_data,
  output logic                     coeff_wr_err,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DW-1:0]            s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [ACCW-1:0]          m_data,
  output logic                     busy
);

  localparam int KW = $clog2(NTAPS);
  localparam int PW = DW + CW;
  localparam logic [KW-1:0] K_LAST = KW'(NTAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

  state_t                 state_q, state_d;
  logic signed [CW-1:0]   coeff [NTAPS];
  logic signed [DW-1:0]   xline [NTAPS];
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] prod_ext;
  logic        [ACCW-1:0] result;
  logic        [KW-1:0]   k;
  logic                   wr_err_q;
  logic                   wr_ok;

  // The product register lags the tap index by one cycle, so the accumulator
  // always folds in the previous tap; DRAIN adds the final product.
  assign prod_ext = ACCW'(prod);

  // Coefficient writes are only safe while no pass is reading the file.
  always_comb begin
    wr_ok = coeff_wr_en && (state_q == IDLE) && (int'(coeff_wr_addr) < NTAPS);
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_d      = state_q;
    s_ready      = (state_q == IDLE) && rst_n;
    m_valid      = (state_q == OUT);
    busy         = (state_q != IDLE);
    m_data       = result;
    coeff_wr_err = wr_err_q;
    case (state_q)
      IDLE:    if (s_valid) state_d = MAC;
      MAC:     if (k == K_LAST) state_d = DRAIN;
      DRAIN:   state_d = OUT;
      OUT:     if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Coefficient file, delay line and MAC datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        coeff[i] <= '0;
        xline[i] <= '0;
      end
      prod     <= '0;
      acc      <= '0;
      k        <= '0;
      result   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= coeff_wr_en && !wr_ok;
      if (wr_ok) coeff[coeff_wr_addr] <= coeff_wr_data;
      case (state_q)
        IDLE: begin
          if (s_valid) begin
            for (int unsigned i = 1; i < NTAPS; i++) xline[i] <= xline[i-1];
            xline[0] <= s_data;
            acc      <= '0;
            prod     <= '0;
            k        <= '0;
          end
        end
        MAC: begin
          prod <= PW'(coeff[k]) * PW'(xline[k]);
          acc  <= acc + prod_ext;
          k    <= k + KW'(1);
        end
        DRAIN: result <= acc + prod_ext;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: directed vector table, hand
// sequences for stall/busy-write/reset corner cases, and randomized traffic
// against a convolution reference model.
module tb_fir_mac_sequencer;

  localparam int NTAPS = 8;
  localparam int ACCW  = 35;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            coeff_wr_en = 1'b0;
  logic [2:0]      coeff_wr_addr = '0;
  logic [15:0]     coeff_wr_data = '0;
  logic            coeff_wr_err;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [15:0]     s_data = '0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [ACCW-1:0] m_data;
  logic            busy;

  // Second instance with a non-power-of-2 tap count for address range checks.
  logic            w5_en = 1'b0;
  logic [2:0]      w5_addr = '0;
  logic            w5_err;
  logic            u5_s_ready, u5_m_valid, u5_busy;
  logic [34:0]     u5_m_data;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.NTAPS(8), .DW(16), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .coeff_wr_en(coeff_wr_en), .coeff_wr_addr(coeff_wr_addr),
    .coeff_wr_data(coeff_wr_data), .coeff_wr_err(coeff_wr_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );

  fir_mac_sequencer #(.NTAPS(5), .DW(16), .CW(16)) u5 (
    .clk(clk), .rst_n(rst_n),
    .coeff_wr_en(w5_en), .coeff_wr_addr(w5_addr),
    .coeff_wr_data(16'h0011), .coeff_wr_err(w5_err),
    .s_valid(1'b0), .s_ready(u5_s_ready), .s_data(16'h0000),
    .m_valid(u5_m_valid), .m_ready(1'b0), .m_data(u5_m_data), .busy(u5_busy)
  );

  int     nchk = 0;
  int     npass = 0;
  longint mc [NTAPS];
  longint hist [$];

  typedef struct {
    longint din;
    longint exp;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input longint got, input longint exp);
    nchk++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // Reference: y[n] = sum_k c[k] * x[n-k], newest sample at the queue front.
  task automatic push_model(input longint d, output longint y);
    hist.push_front(d);
    void'(hist.pop_back());
    y = 0;
    for (int i = 0; i < NTAPS; i++) y += mc[i] * hist[i];
  endtask

  task automatic clear_model();
    hist.delete();
    for (int i = 0; i < NTAPS; i++) begin
      hist.push_back(0);
      mc[i] = 0;
    end
  endtask

  task automatic wr_coeff(input int addr, input longint val);
    coeff_wr_en   = 1'b1;
    coeff_wr_addr = addr[2:0];
    coeff_wr_data = val[15:0];
    @(negedge clk);
    coeff_wr_en = 1'b0;
    chk("wr_err_idle", longint'(coeff_wr_err), 0);
    mc[addr] = val;
  endtask

  // One full transaction; called at a negedge with the DUT idle.
  task automatic send(input longint d, input int stall, output longint y,
                      output int lat, output bit stable);
    logic [ACCW-1:0] md;
    int n;
    s_valid = 1'b1;
    s_data  = d[15:0];
    n = 0;
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    s_valid = 1'b0;
    lat = 0;
    while (!m_valid && lat < 100) begin @(negedge clk); lat++; end
    if (!m_valid) begin
      y = 0; lat = -1; stable = 1'b0;
      return;
    end
    md = m_data;
    y  = longint'($signed(md));
    stable = 1'b1;
    repeat (stall) begin
      @(negedge clk);
      if (m_data !== md || !m_valid) stable = 1'b0;
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  initial begin
    longint y, e, e2;
    int lat;
    bit stable, rdy_bad;
    logic [ACCW-1:0] md;
    logic signed [15:0] r;
    int outs;

    clear_model();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_m_valid", longint'(m_valid), 0);
    chk("rst_s_ready", longint'(s_ready), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_wr_err", longint'(coeff_wr_err), 0);
    chk("rst_m_data", longint'(m_data), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", longint'(s_ready), 1);

    // Address range on NTAPS=5: 4 is legal, 5..7 are dropped
    for (int a = 4; a < 8; a++) begin
      w5_en = 1'b1;
      w5_addr = 3'(a);
      @(negedge clk);
      w5_en = 1'b0;
      chk($sformatf("n5_addr%0d_err", a), longint'(w5_err), (a >= 5) ? 1 : 0);
      @(negedge clk);
      chk($sformatf("n5_addr%0d_pulse", a), longint'(w5_err), 0);
    end

    // Impulse response, c[k] = k+1
    for (int i = 0; i < NTAPS; i++) wr_coeff(i, i + 1);
    tbl[0] = '{1, 1};
    for (int i = 1; i < 9; i++) tbl[i] = '{0, (i < 8) ? i + 1 : 0};
    for (int i = 0; i < 9; i++) begin
      push_model(tbl[i].din, e);
      send(tbl[i].din, 0, y, lat, stable);
      chk($sformatf("impulse[%0d]", i), y, tbl[i].exp);
      chk($sformatf("impulse_model[%0d]", i), y, e);
      chk($sformatf("impulse_lat[%0d]", i), lat, 9);
    end

    // Signed extremes: no wrap in the accumulator
    for (int i = 0; i < NTAPS; i++) wr_coeff(i, -32768);
    for (int i = 0; i < 8; i++) begin
      push_model(-32768, e);
      send(-32768, 0, y, lat, stable);
      chk($sformatf("extreme[%0d]", i), y, e);
    end
    chk("extreme_final", y, 64'sd8589934592);

    // Latency and backpressure with s_valid held high
    s_valid = 1'b1;
    s_data  = 16'd3;
    push_model(3, e);
    @(negedge clk);
    s_data = 16'd4;
    lat = 0;
    rdy_bad = 1'b0;
    while (!m_valid && lat < 100) begin
      if (s_ready) rdy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", lat, 9);
    md = m_data;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (m_data !== md || !m_valid) stable = 1'b0;
      if (s_ready) rdy_bad = 1'b1;
    end
    chk("bp_stable", longint'(stable), 1);
    chk("bp_s_ready_low", longint'(rdy_bad), 0);
    chk("bp_data", longint'($signed(md)), e);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("bp_s_ready_after", longint'(s_ready), 1);
    chk("bp_m_valid_drop", longint'(m_valid), 0);
    push_model(4, e2);
    @(negedge clk);
    s_valid = 1'b0;
    lat = 0;
    while (!m_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("bp2_latency", lat, 9);
    chk("bp2_data", longint'($signed(m_data)), e2);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;

    // Coefficient write while busy is dropped
    push_model(5, e); send(5, 0, y, lat, stable);
    push_model(6, e); send(6, 0, y, lat, stable);
    chk("pre_busy", y, e);
    s_valid = 1'b1;
    s_data  = 16'd7;
    push_model(7, e);
    @(negedge clk);
    s_valid = 1'b0;
    coeff_wr_en   = 1'b1;
    coeff_wr_addr = 3'd2;
    coeff_wr_data = 16'd100;
    @(negedge clk);
    coeff_wr_en = 1'b0;
    chk("busy_wr_err", longint'(coeff_wr_err), 1);
    @(negedge clk);
    chk("busy_wr_pulse", longint'(coeff_wr_err), 0);
    lat = 0;
    while (!m_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("busy_wr_result", longint'($signed(m_data)), e);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    push_model(0, e);
    send(0, 1, y, lat, stable);
    chk("busy_wr_c2_kept", y, e);

    // Reset in the middle of a pass
    s_valid = 1'b1;
    s_data  = 16'd9;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", longint'(m_valid), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_s_ready", longint'(s_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    rdy_bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (m_valid) rdy_bad = 1'b1;
    end
    chk("midrst_no_output", longint'(rdy_bad), 0);
    for (int i = 0; i < NTAPS; i++) begin
      push_model((i == 0) ? 1 : 0, e);
      send((i == 0) ? 1 : 0, 0, y, lat, stable);
      chk($sformatf("midrst_impulse[%0d]", i), y, 0);
    end

    // Randomized traffic against the convolution model
    for (int i = 0; i < NTAPS; i++) begin
      r = 16'($urandom);
      wr_coeff(i, longint'(r));
    end
    outs = 0;
    for (int n = 0; n < 200; n++) begin
      if (n % 50 == 49) begin
        r = 16'($urandom);
        wr_coeff(int'($urandom_range(0, NTAPS - 1)), longint'(r));
      end
      r = 16'($urandom);
      push_model(longint'(r), e);
      send(longint'(r), int'($urandom_range(0, 3)), y, lat, stable);
      if (lat >= 0) outs++;
      chk($sformatf("rand[%0d]", n), y, e);
      if (!stable) chk($sformatf("rand_stable[%0d]", n), 0, 1);
    end
    chk("rand_count", outs, 200);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
